ram_port_arbiter: RTL and testbench

Round-robin arbiter that shares the synchronous write port and the synchronous read port (port 1) of the team's 3-port register-file RAM among `NUM_REQ` requesters. Each requester has independent valid/ready write and read request channels. Read data comes back one cycle later on a shared data bus, with a one-hot response strobe that identifies the owner. The block sits between the client engines and the RAM instance. The RAM's asynchronous read port 0 is not touched and is wired directly by the integrator.

---
 rtl/ram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM write port and one registered read port among NUM_REQ requesters.
// Optional same-cycle write-to-read forwarding is enabled by defining RAM_ARB_FWD_EN.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_wr_valid,
  output logic [NUM_REQ-1:0]               req_wr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
  input  logic [NUM_REQ-1:0]               req_rd_valid,
  output logic [NUM_REQ-1:0]               req_rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd_addr,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            ram_w_addr,
  output logic [DATA_WIDTH-1:0]            ram_w_data,
  output logic                             ram_write_enable,
  output logic [ADDR_WIDTH-1:0]            ram_r_addr1,
  input  logic [DATA_WIDTH-1:0]            ram_r_data1
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW-1:0]      wr_idx, rd_idx;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [NUM_REQ-1:0] rsp_sel;

  // Winner is the valid requester with the smallest distance above the pointer (with wrap).
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [PW-1:0] p);
    int best;
    int d;
    logic [NUM_REQ-1:0] g;
    best = NUM_REQ;
    g    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(p)) % NUM_REQ;
      if (v[i] && d < best) best = d;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      d    = (i + NUM_REQ - int'(p)) % NUM_REQ;
      g[i] = v[i] && (d == best);
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] onehot_idx(input logic [NUM_REQ-1:0] g);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_REQ);
  endfunction

  always_comb begin
    wr_gnt = rst_n ? rr_pick(req_wr_valid, wr_ptr) : '0;
    rd_gnt = rst_n ? rr_pick(req_rd_valid, rd_ptr) : '0;
    wr_idx = onehot_idx(wr_gnt);
    rd_idx = onehot_idx(rd_gnt);
  end

  assign req_wr_ready     = wr_gnt;
  assign req_rd_ready     = rd_gnt;
  assign ram_write_enable = |wr_gnt;
  assign rsp_valid        = rsp_sel;

  always_comb begin
    ram_w_addr  = '0;
    ram_w_data  = '0;
    ram_r_addr1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        ram_w_addr = req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_w_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt[i]) ram_r_addr1 = req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rsp_sel <= '0;
    end else begin
      if (|wr_gnt) wr_ptr <= next_ptr(wr_idx);
      if (|rd_gnt) rd_ptr <= next_ptr(rd_idx);
      rsp_sel <= rd_gnt;
    end
  end

`ifdef RAM_ARB_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  // The RAM reads before the write lands, so a same-address collision is patched here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= (|wr_gnt) && (|rd_gnt) && (ram_w_addr == ram_r_addr1);
      fwd_data <= ram_w_data;
    end
  end

  assign rsp_data = fwd_hit ? fwd_data : ram_r_data1;
`else
  assign rsp_data = ram_r_data1;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_ram_port_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int N  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready, rsp_valid;
  logic [N*AW-1:0]   req_wr_addr, req_rd_addr;
  logic [N*DW-1:0]   req_wr_data;
  logic [DW-1:0]     rsp_data, ram_w_data, ram_r_data1;
  logic [AW-1:0]     ram_w_addr, ram_r_addr1;
  logic              ram_write_enable;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_addr(req_rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data), .ram_write_enable(ram_write_enable),
    .ram_r_addr1(ram_r_addr1), .ram_r_data1(ram_r_data1)
  );

  always #5 clk = ~clk;

  // RAM stand-in: registered read port that samples before the write lands.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_w_addr] <= ram_w_data;
    ram_r_data1 <= ram_mem[ram_r_addr1];
  end

  int tests = 0;
  int fails = 0;

  logic          wv [N];
  logic          rv [N];
  logic [AW-1:0] wa [N];
  logic [AW-1:0] ra [N];
  logic [DW-1:0] wd [N];

  int            m_wptr, m_rptr;
  logic [DW-1:0] m_mem [1<<AW];
  logic [N-1:0]  m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  int            last_wg, last_rg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic v [N], input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b0; rv[i] = 1'b0; wa[i] = '0; ra[i] = '0; wd[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_wr_valid[i]          = wv[i];
      req_rd_valid[i]          = rv[i];
      req_wr_addr[i*AW +: AW]  = wa[i];
      req_rd_addr[i*AW +: AW]  = ra[i];
      req_wr_data[i*DW +: DW]  = wd[i];
    end
  endtask

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_rsp_v = '0;
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance the model, return after the rising edge.
  task automatic step(input bit rst_before_edge = 1'b0);
    int wg, rg;
    drive();
    @(negedge clk);
    wg = rst_n ? pick(wv, m_wptr) : -1;
    rg = rst_n ? pick(rv, m_rptr) : -1;
    chk("wr_ready", 32'(req_wr_ready), (wg >= 0) ? (32'd1 << wg) : 32'd0);
    chk("rd_ready", 32'(req_rd_ready), (rg >= 0) ? (32'd1 << rg) : 32'd0);
    chk("wr_enable", 32'(ram_write_enable), 32'(wg >= 0));
    chk("w_addr", 32'(ram_w_addr), (wg >= 0) ? 32'(wa[wg]) : 32'd0);
    chk("w_data", 32'(ram_w_data), (wg >= 0) ? 32'(wd[wg]) : 32'd0);
    chk("r_addr1", 32'(ram_r_addr1), (rg >= 0) ? 32'(ra[rg]) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v != '0) chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
    last_wg = wg;
    last_rg = rg;
    if (rst_n) begin
      m_rsp_v = (rg >= 0) ? N'(1 << rg) : '0;
      if (rg >= 0) begin
        m_rsp_d = m_mem[ra[rg]];
`ifdef RAM_ARB_FWD_EN
        if (wg >= 0 && wa[wg] == ra[rg]) m_rsp_d = wd[wg];
`endif
      end
      if (wg >= 0) begin
        m_mem[wa[wg]] = wd[wg];
        m_wptr = (wg + 1) % N;
      end
      if (rg >= 0) m_rptr = (rg + 1) % N;
    end else begin
      m_rsp_v = '0;
    end
    if (rst_before_edge) begin
      #2 rst_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] coll_exp;
    clear();
    model_reset();
    drive();
    step();
    rst_n = 1'b1;

    // Preload every address through requester 0 so later reads have known contents.
    for (int a = 0; a < (1 << AW); a++) begin
      clear();
      wv[0] = 1'b1; wa[0] = AW'(a); wd[0] = 8'($urandom);
      step();
    end

    // Reset with all requesters asking, then rotation from requester 0.
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b1; rv[i] = 1'b1;
      wa[i] = AW'(i + 1); ra[i] = AW'(i + 4); wd[i] = 8'(8'h30 + i);
    end
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) step();

    // Write then read by a different requester.
    clear();
    wv[1] = 1'b1; wa[1] = 3'd3; wd[1] = 8'hA5;
    step();
    clear();
    rv[2] = 1'b1; ra[2] = 3'd3;
    step();
    chk("wr_then_rd_valid", 32'(rsp_valid), 32'b100);
    chk("wr_then_rd_data", 32'(rsp_data), 32'hA5);
    clear();
    step();

    // Wrap: move rd_ptr to 2, then only requester 0 reads.
    rv[1] = 1'b1; ra[1] = 3'd1;
    step();
    clear();
    rv[0] = 1'b1; ra[0] = 3'd2;
    step();
    chk("wrap_grant", 32'(last_rg), 32'd0);
    rv[1] = 1'b1; ra[1] = 3'd6;
    step();
    chk("wrap_ptr_next", 32'(last_rg), 32'd1);

    // Same-cycle collision on address 5.
    clear();
    wv[0] = 1'b1; wa[0] = 3'd5; wd[0] = 8'h11;
    step();
    clear();
    wv[0] = 1'b1; wa[0] = 3'd5; wd[0] = 8'h22;
    rv[1] = 1'b1; ra[1] = 3'd5;
    step();
`ifdef RAM_ARB_FWD_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    chk("collision_valid", 32'(rsp_valid), 32'b010);
    chk("collision_data", 32'(rsp_data), 32'(coll_exp));

    // Reset asserted between a read grant and its response edge.
    clear();
    rv[2] = 1'b1; ra[2] = 3'd7;
    step(1'b1);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b1; rv[i] = 1'b1; wd[i] = 8'(8'h50 + i);
    end
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_wr_first", 32'(last_wg), 32'd0);
    chk("post_rst_rd_first", 32'(last_rg), 32'd0);

    // Randomized traffic; a valid request is held until it is granted.
    clear();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wv[i] || last_wg == i) begin
          wv[i] = 1'($urandom_range(0, 1)); wa[i] = AW'($urandom); wd[i] = 8'($urandom);
        end
        if (!rv[i] || last_rg == i) begin
          rv[i] = 1'($urandom_range(0, 1)); ra[i] = AW'($urandom);
        end
      end
      step();
    end
    clear();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
